// File: rtl/tw_cmd_sequencer.sv
// Command front-end for the threewire master: queues register read/write
// requests, issues them one at a time and returns read data on a response port.
module tw_cmd_sequencer #(
   parameter int ADDR_BITS      = 9,
   parameter int DATA_BITS      = 16,
   parameter int DEPTH          = 4,
   parameter int PTR_BITS       = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 in_clk,
   input  logic                 in_rst_n,
   input  logic                 in_cmd_valid,
   output logic                 out_cmd_ready,
   input  logic                 in_cmd_wr,
   input  logic [ADDR_BITS-1:0] in_cmd_addr,
   input  logic [DATA_BITS-1:0] in_cmd_data,
   output logic                 out_rsp_valid,
   input  logic                 in_rsp_ready,
   output logic [ADDR_BITS-1:0] out_rsp_addr,
   output logic [DATA_BITS-1:0] out_rsp_data,
   output logic                 out_rsp_err,
   output logic                 out_tw_start,
   output logic                 out_tw_mode_wr,
   output logic [ADDR_BITS-1:0] out_tw_addr,
   output logic [DATA_BITS-1:0] out_tw_wr_data,
   input  logic                 in_tw_active,
   input  logic [DATA_BITS-1:0] in_tw_rd_data,
   output logic                 out_busy,
   output logic [PTR_BITS:0]    out_fifo_level,
   output logic                 out_timeout_err,
   input  logic                 in_err_clr
);

   localparam int CNT_BITS   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int ENTRY_BITS = 1 + ADDR_BITS + DATA_BITS;

   localparam logic [PTR_BITS:0]    LVL_FULL = DEPTH[PTR_BITS:0];
   localparam logic [PTR_BITS:0]    LVL_ZERO = {(PTR_BITS+1){1'b0}};
   localparam logic [PTR_BITS:0]    LVL_ONE  = (PTR_BITS+1)'(1'b1);
   localparam logic [PTR_BITS-1:0]  PTR_ONE  = PTR_BITS'(1'b1);
   localparam logic [CNT_BITS-1:0]  CNT_ZERO = {CNT_BITS{1'b0}};
   localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1'b1);
   localparam logic [CNT_BITS-1:0]  CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_RSP       = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [ENTRY_BITS-1:0]  mem_q [DEPTH];
   logic [ENTRY_BITS-1:0]  mem_d [DEPTH];
   logic [PTR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_BITS:0]      level_q, level_d;
   logic                   cmd_ready_q, cmd_ready_d;
   logic                   busy_q, busy_d;
   logic [CNT_BITS-1:0]    cnt_q, cnt_d;
   logic                   tw_start_q, tw_start_d;
   logic                   tw_mode_wr_q, tw_mode_wr_d;
   logic [ADDR_BITS-1:0]   tw_addr_q, tw_addr_d;
   logic [DATA_BITS-1:0]   tw_wr_data_q, tw_wr_data_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [ADDR_BITS-1:0]   rsp_addr_q, rsp_addr_d;
   logic [DATA_BITS-1:0]   rsp_data_q, rsp_data_d;
   logic                   rsp_err_q, rsp_err_d;
   logic                   timeout_err_q, timeout_err_d;

   logic                   push_s;
   logic                   pop_s;
   logic                   timeout_s;
   logic                   head_wr_s;
   logic [ADDR_BITS-1:0]   head_addr_s;
   logic [DATA_BITS-1:0]   head_data_s;

   // Next-state logic for the FIFO, the sequencing FSM and all registered outputs.
   always_comb begin
      state_d       = state_q;
      mem_d         = mem_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      level_d       = level_q;
      cnt_d         = cnt_q;
      tw_start_d    = tw_start_q;
      tw_mode_wr_d  = tw_mode_wr_q;
      tw_addr_d     = tw_addr_q;
      tw_wr_data_d  = tw_wr_data_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_addr_d    = rsp_addr_q;
      rsp_data_d    = rsp_data_q;
      rsp_err_d     = rsp_err_q;
      timeout_s     = 1'b0;

      push_s = in_cmd_valid & cmd_ready_q;
      pop_s  = (state_q == ST_IDLE) && (level_q != LVL_ZERO);
      {head_wr_s, head_addr_s, head_data_s} = mem_q[rd_ptr_q];

      if (push_s) begin
         mem_d[wr_ptr_q] = {in_cmd_wr, in_cmd_addr, in_cmd_data};
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d        = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase

      case (state_q)
         ST_IDLE: begin
            if (pop_s) begin
               tw_mode_wr_d = head_wr_s;
               tw_addr_d    = head_addr_s;
               tw_wr_data_d = head_data_s;
               tw_start_d   = 1'b1;
               cnt_d        = CNT_ZERO;
               state_d      = ST_START;
            end else begin
               state_d      = ST_IDLE;
            end
         end
         ST_START: begin
            // An in-progress master always beats a coincident timeout.
            if (in_tw_active) begin
               tw_start_d = 1'b0;
               cnt_d      = CNT_ZERO;
               state_d    = ST_WAIT_DONE;
            end else if (cnt_q == CNT_LAST) begin
               tw_start_d = 1'b0;
               cnt_d      = CNT_ZERO;
               timeout_s  = 1'b1;
               if (!tw_mode_wr_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_addr_d  = tw_addr_q;
                  rsp_data_d  = {DATA_BITS{1'b1}};
                  rsp_err_d   = 1'b1;
                  state_d     = ST_RSP;
               end else begin
                  state_d     = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_WAIT_DONE: begin
            if (!in_tw_active) begin
               if (!tw_mode_wr_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_addr_d  = tw_addr_q;
                  rsp_data_d  = in_tw_rd_data;
                  rsp_err_d   = 1'b0;
                  state_d     = ST_RSP;
               end else begin
                  state_d     = ST_IDLE;
               end
            end else begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_RSP: begin
            if (in_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_RSP;
            end
         end
         default: begin
            tw_start_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase

      if (timeout_s) begin
         timeout_err_d = 1'b1;
      end else if (in_err_clr) begin
         timeout_err_d = 1'b0;
      end else begin
         timeout_err_d = timeout_err_q;
      end

      cmd_ready_d = (level_d != LVL_FULL);
      busy_d      = (state_d != ST_IDLE) || (level_d != LVL_ZERO);
   end

   // State and output registers; reset abandons any command in flight.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q       <= ST_IDLE;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {ENTRY_BITS{1'b0}};
         end
         wr_ptr_q      <= {PTR_BITS{1'b0}};
         rd_ptr_q      <= {PTR_BITS{1'b0}};
         level_q       <= LVL_ZERO;
         cmd_ready_q   <= 1'b1;
         busy_q        <= 1'b0;
         cnt_q         <= CNT_ZERO;
         tw_start_q    <= 1'b0;
         tw_mode_wr_q  <= 1'b0;
         tw_addr_q     <= {ADDR_BITS{1'b0}};
         tw_wr_data_q  <= {DATA_BITS{1'b0}};
         rsp_valid_q   <= 1'b0;
         rsp_addr_q    <= {ADDR_BITS{1'b0}};
         rsp_data_q    <= {DATA_BITS{1'b0}};
         rsp_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         cmd_ready_q   <= cmd_ready_d;
         busy_q        <= busy_d;
         cnt_q         <= cnt_d;
         tw_start_q    <= tw_start_d;
         tw_mode_wr_q  <= tw_mode_wr_d;
         tw_addr_q     <= tw_addr_d;
         tw_wr_data_q  <= tw_wr_data_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_addr_q    <= rsp_addr_d;
         rsp_data_q    <= rsp_data_d;
         rsp_err_q     <= rsp_err_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign out_cmd_ready   = cmd_ready_q;
   assign out_busy        = busy_q;
   assign out_fifo_level  = level_q;
   assign out_tw_start    = tw_start_q;
   assign out_tw_mode_wr  = tw_mode_wr_q;
   assign out_tw_addr     = tw_addr_q;
   assign out_tw_wr_data  = tw_wr_data_q;
   assign out_rsp_valid   = rsp_valid_q;
   assign out_rsp_addr    = rsp_addr_q;
   assign out_rsp_data    = rsp_data_q;
   assign out_rsp_err     = rsp_err_q;
   assign out_timeout_err = timeout_err_q;

endmodule

// File: tb/tb_tw_cmd_sequencer.sv
// Directed self-checking bench for tw_cmd_sequencer; the bench itself plays the
// threewire master and the response consumer.
module tb_tw_cmd_sequencer;

   logic        in_clk;
   logic        in_rst_n;
   logic        in_cmd_valid;
   logic        out_cmd_ready;
   logic        in_cmd_wr;
   logic [8:0]  in_cmd_addr;
   logic [15:0] in_cmd_data;
   logic        out_rsp_valid;
   logic        in_rsp_ready;
   logic [8:0]  out_rsp_addr;
   logic [15:0] out_rsp_data;
   logic        out_rsp_err;
   logic        out_tw_start;
   logic        out_tw_mode_wr;
   logic [8:0]  out_tw_addr;
   logic [15:0] out_tw_wr_data;
   logic        in_tw_active;
   logic [15:0] in_tw_rd_data;
   logic        out_busy;
   logic [2:0]  out_fifo_level;
   logic        out_timeout_err;
   logic        in_err_clr;

   int checks      = 0;
   int failures    = 0;
   int rsp_count   = 0;
   int start_count = 0;

   tw_cmd_sequencer dut (
      .in_clk          (in_clk),
      .in_rst_n        (in_rst_n),
      .in_cmd_valid    (in_cmd_valid),
      .out_cmd_ready   (out_cmd_ready),
      .in_cmd_wr       (in_cmd_wr),
      .in_cmd_addr     (in_cmd_addr),
      .in_cmd_data     (in_cmd_data),
      .out_rsp_valid   (out_rsp_valid),
      .in_rsp_ready    (in_rsp_ready),
      .out_rsp_addr    (out_rsp_addr),
      .out_rsp_data    (out_rsp_data),
      .out_rsp_err     (out_rsp_err),
      .out_tw_start    (out_tw_start),
      .out_tw_mode_wr  (out_tw_mode_wr),
      .out_tw_addr     (out_tw_addr),
      .out_tw_wr_data  (out_tw_wr_data),
      .in_tw_active    (in_tw_active),
      .in_tw_rd_data   (in_tw_rd_data),
      .out_busy        (out_busy),
      .out_fifo_level  (out_fifo_level),
      .out_timeout_err (out_timeout_err),
      .in_err_clr      (in_err_clr)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   // Count accepted responses and issued start pulses.
   always @(posedge in_clk) begin
      if (out_rsp_valid && in_rsp_ready) rsp_count <= rsp_count + 1;
   end

   always @(posedge out_tw_start) start_count = start_count + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic push(input logic wr, input logic [8:0] addr, input logic [15:0] data);
      in_cmd_valid = 1'b1;
      in_cmd_wr    = wr;
      in_cmd_addr  = addr;
      in_cmd_data  = data;
      tick();
      in_cmd_valid = 1'b0;
   endtask

   task automatic wait_start(input int max_cycles);
      int n = 0;
      while (!out_tw_start && n < max_cycles) begin
         tick();
         n = n + 1;
      end
      chk("start_seen", out_tw_start, 1);
   endtask

   // One master transaction: active high for busy_cyc edges, then low for one edge.
   task automatic master_cycle(input logic [15:0] rd, input int busy_cyc);
      in_tw_rd_data = rd;
      in_tw_active  = 1'b1;
      repeat (busy_cyc) tick();
      chk("start_dropped", out_tw_start, 0);
      in_tw_active  = 1'b0;
      tick();
   endtask

   initial begin
      int n;
      in_rst_n      = 1'b1;
      in_cmd_valid  = 1'b0;
      in_cmd_wr     = 1'b0;
      in_cmd_addr   = 9'h000;
      in_cmd_data   = 16'h0000;
      in_rsp_ready  = 1'b0;
      in_tw_active  = 1'b0;
      in_tw_rd_data = 16'h0000;
      in_err_clr    = 1'b0;
      #1 in_rst_n = 1'b0;
      #2;
      chk("rst_ready", out_cmd_ready, 1);
      chk("rst_level", out_fifo_level, 0);
      chk("rst_start", out_tw_start, 0);
      chk("rst_busy", out_busy, 0);
      chk("rst_rsp", {out_rsp_valid, out_rsp_err, out_rsp_addr, out_rsp_data}, 0);
      chk("rst_tw", {out_tw_mode_wr, out_tw_addr, out_tw_wr_data}, 0);
      chk("rst_terr", out_timeout_err, 0);
      tick();
      tick();
      in_rst_n = 1'b1;

      // Single read of 0x003.
      in_rsp_ready = 1'b1;
      push(1'b0, 9'h003, 16'h0000);
      chk("rd_level1", out_fifo_level, 1);
      chk("rd_busy", out_busy, 1);
      chk("rd_nostart", out_tw_start, 0);
      tick();
      chk("rd_start", out_tw_start, 1);
      chk("rd_tw", {out_tw_mode_wr, out_tw_addr}, {1'b0, 9'h003});
      chk("rd_level0", out_fifo_level, 0);
      master_cycle(16'h003D, 1);
      chk("rd_rsp", {out_rsp_valid, out_rsp_err, out_rsp_addr, out_rsp_data},
          {1'b1, 1'b0, 9'h003, 16'h003D});
      tick();
      chk("rd_rsp_done", {out_rsp_valid, out_busy}, 0);

      // Write 0x04E then read 0x04E on consecutive cycles.
      in_cmd_valid = 1'b1;
      in_cmd_wr    = 1'b1;
      in_cmd_addr  = 9'h04E;
      in_cmd_data  = 16'h0049;
      tick();
      in_cmd_wr    = 1'b0;
      in_cmd_data  = 16'h0000;
      tick();
      in_cmd_valid = 1'b0;
      chk("wr_issue", {out_tw_start, out_tw_mode_wr, out_tw_addr, out_tw_wr_data},
          {1'b1, 1'b1, 9'h04E, 16'h0049});
      chk("wr_level", out_fifo_level, 1);
      master_cycle(16'h0000, 2);
      chk("wr_gap", {out_tw_start, out_rsp_valid}, 0);
      tick();
      chk("rd2_issue", {out_tw_start, out_tw_mode_wr, out_tw_addr, out_fifo_level},
          {1'b1, 1'b0, 9'h04E, 3'd0});
      master_cycle(16'h0049, 1);
      chk("rd2_rsp", {out_rsp_valid, out_rsp_err, out_rsp_addr, out_rsp_data},
          {1'b1, 1'b0, 9'h04E, 16'h0049});
      tick();
      chk("rd2_done", out_rsp_valid, 0);

      // Fill the FIFO behind a stalled write, then let the write time out.
      push(1'b1, 9'h100, 16'h1111);
      tick();
      chk("full_a_start", out_tw_start, 1);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         chk("full_ready", out_cmd_ready, (i < 4) ? 1 : 0);
         in_cmd_valid = 1'b1;
         in_cmd_wr    = 1'b1;
         in_cmd_addr  = 9'h010 + 9'(i);
         in_cmd_data  = 16'hA000 + 16'(i);
         tick();
         n = n + 1;
      end
      in_cmd_valid = 1'b0;
      chk("full_level", {out_fifo_level, out_cmd_ready}, {3'd4, 1'b0});
      while (out_tw_start && n < 300) begin
         tick();
         n = n + 1;
      end
      chk("wr_to_cycles", n, 255);
      chk("wr_to_flags", {out_timeout_err, out_rsp_valid}, {1'b1, 1'b0});
      in_err_clr = 1'b1;
      tick();
      in_err_clr = 1'b0;
      chk("err_clr", out_timeout_err, 0);
      chk("b0_level", out_fifo_level, 3);
      for (int i = 0; i < 4; i++) begin
         wait_start(4);
         chk("fifo_order", {out_tw_mode_wr, out_tw_addr, out_tw_wr_data},
             {1'b1, 9'h010 + 9'(i), 16'hA000 + 16'(i)});
         master_cycle(16'h0000, 1);
      end
      tick();
      tick();
      chk("fifo_drained", {out_tw_start, out_busy, out_fifo_level}, 0);

      // Read timeout with response held off until released.
      in_rsp_ready = 1'b0;
      push(1'b0, 9'h055, 16'h0000);
      wait_start(4);
      n = 0;
      while (out_tw_start && n < 300) begin
         tick();
         n = n + 1;
      end
      chk("rd_to_cycles", n, 255);
      chk("rd_to_rsp", {out_rsp_valid, out_rsp_err, out_rsp_addr, out_rsp_data},
          {1'b1, 1'b1, 9'h055, 16'hFFFF});
      chk("rd_to_flag", out_timeout_err, 1);
      in_rsp_ready = 1'b1;
      in_err_clr   = 1'b1;
      tick();
      in_err_clr   = 1'b0;
      chk("rd_to_done", {out_rsp_valid, out_timeout_err}, 0);

      // Response backpressure holds the next queued command.
      in_rsp_ready = 1'b0;
      in_cmd_valid = 1'b1;
      in_cmd_wr    = 1'b0;
      in_cmd_addr  = 9'h0AA;
      tick();
      in_cmd_wr    = 1'b1;
      in_cmd_addr  = 9'h0BB;
      in_cmd_data  = 16'h5555;
      tick();
      in_cmd_valid = 1'b0;
      chk("bp_issue", {out_tw_start, out_tw_addr}, {1'b1, 9'h0AA});
      master_cycle(16'h1234, 1);
      for (int i = 0; i < 20; i++) begin
         chk("bp_hold", {out_rsp_valid, out_tw_start, out_fifo_level, out_rsp_data},
             {1'b1, 1'b0, 3'd1, 16'h1234});
         tick();
      end
      in_rsp_ready = 1'b1;
      tick();
      chk("bp_accept", {out_rsp_valid, out_tw_start}, 0);
      tick();
      chk("bp_next", {out_tw_start, out_tw_mode_wr, out_tw_addr, out_tw_wr_data},
          {1'b1, 1'b1, 9'h0BB, 16'h5555});
      master_cycle(16'h0000, 1);

      // Reset during WAIT_DONE with two commands queued.
      push(1'b0, 9'h0CC, 16'h0000);
      wait_start(4);
      push(1'b0, 9'h0DD, 16'h0000);
      push(1'b1, 9'h0EE, 16'h7777);
      chk("rst_q_level", out_fifo_level, 2);
      in_tw_active = 1'b1;
      tick();
      chk("rst_q_wait", out_tw_start, 0);
      in_rst_n = 1'b0;
      #1;
      chk("mid_rst_out", {out_tw_start, out_busy, out_fifo_level, out_cmd_ready, out_tw_addr},
          {1'b0, 1'b0, 3'd0, 1'b1, 9'h000});
      chk("mid_rst_rsp", {out_rsp_valid, out_timeout_err}, 0);
      in_tw_active = 1'b0;
      tick();
      tick();
      in_rst_n = 1'b1;
      repeat (10) tick();
      chk("post_rst_idle", {out_busy, out_tw_start, out_rsp_valid}, 0);
      chk("rsp_total", rsp_count, 4);
      chk("start_total", start_count, 12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tw_cmd_sequencer.md
Name: tw_cmd_sequencer

Overview:
- Command front-end placed directly upstream of the threewire master.
- Accepts register read/write requests on a valid/ready interface and buffers them in a small FIFO.
- Issues them one at a time to the master using its level start / in-progress handshake.
- Returns read data, with an error flag, on a valid/ready response interface; writes complete silently.

Parameters:
ADDR_BITS, 9, register address width (matches master).
DATA_BITS, 16, register data width (matches master).
DEPTH, 4, command FIFO entries (power of 2, >=2).
PTR_BITS, 2, log2(DEPTH).
TIMEOUT_CYCLES, 255, max cycles in START waiting for master in-progress.

Ports:
in_clk  input  1  system clock, all logic on rising edge.
in_rst_n  input  1  asynchronous, active-low reset.
in_cmd_valid  input  1  command offered.
out_cmd_ready  output  1  FIFO can accept (not full).
in_cmd_wr  input  1  1 = write, 0 = read.
in_cmd_addr  input  ADDR_BITS  register address.
in_cmd_data  input  DATA_BITS  write data (ignored for reads).
out_rsp_valid  output  1  read response available.
in_rsp_ready  input  1  consumer accepts response.
out_rsp_addr  output  ADDR_BITS  address of completed read.
out_rsp_data  output  DATA_BITS  read data.
out_rsp_err  output  1  read was dropped on timeout.
out_tw_start  output  1  to master start input.
out_tw_mode_wr  output  1  to master mode input.
out_tw_addr  output  ADDR_BITS  to master address.
out_tw_wr_data  output  DATA_BITS  to master write data.
in_tw_active  input  1  master in-progress flag (same clock domain).
in_tw_rd_data  input  DATA_BITS  master read data.
out_busy  output  1  FSM not IDLE or FIFO non-empty.
out_fifo_level  output  PTR_BITS+1  FIFO occupancy, 0..DEPTH.
out_timeout_err  output  1  sticky timeout flag.
in_err_clr  input  1  clears out_timeout_err.

Behaviour:
- Reset: in_rst_n low clears all registers immediately.
  - FIFO empty, level 0, out_cmd_ready=1.
  - FSM=IDLE, out_tw_start=0.
  - out_tw_mode_wr/addr/wr_data=0.
  - out_rsp_valid=0, rsp addr/data/err=0.
  - out_timeout_err=0, out_busy=0.
- Reset mid-transaction: the sequencer abandons the command. The master is not aborted; it has its own reset.
- FIFO push: in_cmd_valid & out_cmd_ready at an edge stores {wr, addr, data}.
- FIFO pop: occurs only in IDLE when the FIFO is non-empty.
- Simultaneous push and pop: level unchanged; both pointers advance.
- Full (level == DEPTH): out_cmd_ready=0; offered commands are not stored.
- Pointers wrap modulo DEPTH.
- FSM IDLE: if the FIFO is non-empty, pop the head, register it onto out_tw_mode_wr/addr/wr_data, set out_tw_start=1, go START.
  - Latency: command pushed into an empty idle FIFO at edge E gives out_tw_start=1 after edge E+1.
- FSM START: hold out_tw_start and the master inputs stable.
  - Timeout counter increments each cycle.
  - When in_tw_active=1 is sampled: out_tw_start=0, clear counter, go WAIT_DONE.
  - When the counter reaches TIMEOUT_CYCLES without active: out_tw_start=0, set out_timeout_err.
    - Read: go RSP with data all-ones, err=1.
    - Write: go IDLE.
  - If active and timeout coincide, active wins.
- FSM WAIT_DONE: wait for in_tw_active=0.
  - On that edge, a read captures in_tw_rd_data into out_rsp_data, captures the address into out_rsp_addr, sets err=0, and goes RSP.
  - A write goes IDLE.
- FSM RSP: out_rsp_valid=1 with stable addr/data/err until in_rsp_ready=1 at an edge, then out_rsp_valid=0, go IDLE.
  - No new command starts while a response is pending; at most one response is outstanding.
- out_tw_start is never reasserted before in_tw_active has been seen low.
  - Back-to-back commands therefore have at least one IDLE cycle between them.
- out_timeout_err: set by timeout, cleared by in_err_clr. Set wins if both occur in the same cycle.
- out_busy = (FSM != IDLE) | (level != 0).

Test Plan:
- Read 0x003, slave data 0x003D, in_rsp_ready=1 -> one out_tw_start pulse; out_rsp_valid with addr 0x003, data 0x003D, err=0; FSM back to IDLE.
- Write 0x04E/0x0049 then read 0x04E (slave returns 0x0049), pushed on consecutive cycles -> master sees write first with mode_wr=1, then the read; exactly one response with data 0x0049; no overlap of start and active.
- Push 5 commands with no master activity (active tied 0) -> out_cmd_ready drops at level 4; 5th not stored.
- Timeout case (active tied 0): a read times out after 255 START cycles -> out_timeout_err=1; rsp data 0xFFFF, err=1; in_err_clr returns the flag to 0.
- Response backpressure: read completes with in_rsp_ready=0 for 20 cycles -> valid/data held stable, next queued command not started; starts after acceptance.
- Assert in_rst_n=0 during WAIT_DONE with 2 queued commands -> all outputs reset immediately, level 0, no response emitted after release.
